intt_output_collector: RTL
==========================

# intt_output_collector

Collects the final-iteration coefficient pairs emitted by the INTT router and stores a complete polynomial. It then streams that polynomial out in natural coefficient order over a valid/ready interface. It sits directly downstream of the router's `out`/`address_out` ports and upstream of the host/DMA read path. It decouples the router's fixed-rate burst (no backpressure) from a stallable consumer.

## Interface
Parameters:
- `LOG_CORE_COUNT`, default 5: log2 of butterfly core count; must match the router.
- `LOG_N`, default 12, from the package: log2 of polynomial length.

Ports:
- `clk` input, 1 bit: single clock, all logic on rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `in_valid` input, 1 bit: router `out`/`address_out` carry a valid final-phase beat this cycle.
- `in` input, 60 bits × CORES × 2: `in[k][0]={c1,c0}`, `in[k][1]={c3,c2}`, where CORES = 1<<LOG_CORE_COUNT.
- `address_in` input, 9 bits: router `address_out`.
- `in_ready` output, 1 bit: a bank is available to fill; the controller must not start the last INTT iteration while this is low.
- `m_valid` output, 1 bit: output beat valid.
- `m_ready` input, 1 bit: consumer accepts the beat.
- `m_data` output, 120 bits: `{c3,c2,c1,c0}`, four consecutive coefficients.
- `m_last` output, 1 bit: final beat of the polynomial.
- `err` output, 1 bit: sticky error flag.

## Operation
- W = 1<<(LOG_N−LOG_CORE_COUNT−2) words per core; W=32 at the defaults. Valid addresses are 0..W−1.
- Coefficient index of `in[k][h]` half j is k·4W + 4·address + 2h + j.
- Fill FSM states are IDLE, FILL and FULL.
  - IDLE → FILL on the first accepted `in_valid`.
  - Each accepted beat writes all CORES lanes at `address_in` and sets bit `address_in` of a W-bit written-mask.
  - FILL → FULL when the mask becomes all-ones. FULL hands the bank to drain and clears the mask.
- Drain FSM states are D_IDLE, D_RUN and D_LAST.
  - Beat counter b runs 0..CORES·W−1. Beat b reads core b>>log2(W), word b&(W−1).
  - `m_last` is asserted at b = CORES·W−1. The handshake on that beat releases the bank and returns to D_IDLE.
- Errors set `err` (cleared only by reset):
  - `address_in` ≥ W: beat dropped.
  - Duplicate address within one fill (mask bit already set): data overwritten, not counted.
  - `in_valid` while `in_ready`=0: beat dropped, no state change.
- Simultaneous fill completion and drain release of the other bank are both honoured in the same cycle.
- Reset mid-operation discards all banks, masks and counters. Memory contents are don't-care.

## Timing
- Reset values: `in_ready`=1, `m_valid`=0, `m_last`=0, `m_data`=0, `err`=0. Both FSMs are idle and all masks are clear.
- Write: a beat sampled on edge e is stored on edge e.
- Fill-to-stream latency: if the last fill beat is sampled on edge e, `m_valid` rises after edge e+2.
  - Edge e+1: bank handoff.
  - Edge e+2: registered read.
- Streaming: one beat per cycle while `m_ready`=1. This uses a registered read plus a 1-entry skid register, so there are no bubbles.
- Stall: while `m_valid`=1 and `m_ready`=0, `m_data`/`m_last` are held stable.
- `in_ready` changes on clock edges only.
  - Without double buffering, it falls on the edge that completes a fill.
  - It rises the cycle after the `m_last` handshake.

## Configuration
- `INTT_OUT_DOUBLE_BUF_EN` defined:
  - Two banks in ping-pong. Fill writes bank f while drain reads bank d.
  - `in_ready`=0 only when both banks are full or draining.
  - A new polynomial may be filled back-to-back with no idle cycle.
- `INTT_OUT_DOUBLE_BUF_EN` undefined:
  - One bank. `in_ready`=0 from fill completion until the `m_last` handshake.
  - Fill and drain never overlap.

## Structure
- Shared package `intt_pkg` holds:
  - `LOG_N`, `COEFF_W`=30, `PAIR_W`=60, `ADDR_W`=9.
  - The fill/drain state enums.
  - A `coeff_quad_t` 120-bit typedef.
- Sub-module `intt_out_bank` is one bank: CORES×W×120-bit storage, synchronous write of all lanes, registered single-lane read. It is instantiated once or twice depending on the macro.

## Test plan
- Ordered fill: 32 beats, address 0..31, `in[k][h]` = index-encoded values, `m_ready`=1. Required response:
  - 1024 beats with `m_data` = {4b+3, 4b+2, 4b+1, 4b}.
  - `m_valid` rises 2 cycles after the last input.
  - `m_last` only on beat 1023.
- Shuffled address order (31..0) → identical output stream, `err`=0.
- Random `m_ready` at 30% duty → no lost or duplicated beats, and `m_data` stable during every stall.
- Error cases: `address_in`=40 → `err`=1 and the beat is ignored. Repeated address 5 → `err`=1, and the fill completes only after all 32 distinct addresses.
- Second polynomial during drain:
  - With the macro: `in_ready` stays 1 and both polynomials stream in order.
  - Without the macro: `in_ready`=0, the beats are dropped and `err`=1.
- Assert `rst_n` low at beat 500 of the drain → all outputs return to reset values immediately. A fresh fill afterwards streams correctly.

Source files
------------

// File: rtl/intt_pkg.sv
// intt_pkg: shared widths, state enums and coefficient types for the INTT output path
package intt_pkg;
  localparam int LOG_N = 12;
  localparam int COEFF_W = 30;
  localparam int PAIR_W = 60;
  localparam int ADDR_W = 9;
  typedef enum logic [1:0] {IDLE, FILL, FULL} fill_state_t;
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_LAST} drain_state_t;
  typedef logic [4*COEFF_W-1:0] coeff_quad_t;
endpackage

// File: rtl/intt_out_bank.sv
// intt_out_bank: one polynomial bank, full-row write of all core lanes, registered single-lane read
module intt_out_bank import intt_pkg::*; #(
  parameter int LOG_CORE_COUNT = 5,
  localparam int CORES = 1 << LOG_CORE_COUNT,
  localparam int LW = LOG_N - LOG_CORE_COUNT - 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              we,
  input  logic [LW-1:0]                     waddr,
  input  logic [CORES-1:0][1:0][PAIR_W-1:0] wdata,
  input  logic                              re,
  input  logic [LOG_N-3:0]                  raddr,
  output coeff_quad_t                       rdata
);
  logic [CORES-1:0][1:0][PAIR_W-1:0] mem [1<<LW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr[LW-1:0]][raddr[LOG_N-3:LW]];
endmodule

// File: rtl/intt_output_collector.sv
// intt_output_collector: gathers final INTT beats into a bank and streams the polynomial in natural order.
// Define INTT_OUT_DOUBLE_BUF_EN for two ping-pong banks so a new fill can overlap the drain.
module intt_output_collector import intt_pkg::*; #(
  parameter int LOG_CORE_COUNT = 5,
  localparam int CORES = 1 << LOG_CORE_COUNT,
  localparam int LW = LOG_N - LOG_CORE_COUNT - 2,
  localparam int W = 1 << LW
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [CORES-1:0][1:0][PAIR_W-1:0] in,
  input  logic [ADDR_W-1:0]                 address_in,
  output logic                              in_ready,
  output logic                              m_valid,
  input  logic                              m_ready,
  output coeff_quad_t                       m_data,
  output logic                              m_last,
  output logic                              err
);
`ifdef INTT_OUT_DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic PP = NB == 2;
  localparam logic [LOG_N-3:0] LAST_B = '1;
  fill_state_t fs, fs_n;
  drain_state_t ds, ds_n;
  logic f, d, tgt, acc, dup, done, issue, cons, rel;
  logic rv, rl, sv, sl;
  logic [NB-1:0] busy;
  logic [W-1:0] mask, mask_b, mask_n;
  logic [LOG_N-3:0] b;
  coeff_quad_t s_data;
  coeff_quad_t rd [NB];
  assign m_valid = sv || rv;
  assign m_data = sv ? s_data : rd[d];
  assign m_last = sv ? sl : rv && rl;
  // In FULL the completed bank is being handed off, so new beats target the other bank
  always_comb begin
    tgt = fs == FULL ? f ^ PP : f;
    in_ready = !busy[tgt];
    acc = in_valid && in_ready && address_in < ADDR_W'(W);
    mask_b = fs == FULL ? '0 : mask;
    dup = acc && mask_b[address_in[LW-1:0]];
    mask_n = mask_b | (acc ? W'(1) << address_in[LW-1:0] : '0);
    done = acc && &mask_n;
    fs_n = done ? FULL : acc ? FILL : fs == FULL ? IDLE : fs;
    cons = m_valid && m_ready;
    rel = ds == D_LAST && cons && m_last;
    issue = ds == D_RUN && !sv;
    ds_n = ds == D_IDLE && busy[d] ? D_RUN : ds == D_RUN && issue && b == LAST_B ? D_LAST : rel ? D_IDLE : ds;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fs <= IDLE;
      ds <= D_IDLE;
      f <= 1'b0;
      d <= 1'b0;
      busy <= '0;
      mask <= '0;
      err <= 1'b0;
      b <= '0;
      rv <= 1'b0;
      rl <= 1'b0;
      sv <= 1'b0;
      sl <= 1'b0;
      s_data <= '0;
    end else begin
      fs <= fs_n;
      ds <= ds_n;
      mask <= mask_n;
      if (fs == FULL) f <= f ^ PP;
      if (rel) d <= d ^ PP;
      busy <= busy & ~({NB{rel}} & (NB'(1) << d)) | ({NB{done}} & (NB'(1) << tgt));
      err <= err || (in_valid && (!in_ready || address_in >= ADDR_W'(W) || dup));
      if (issue) b <= b + 1'b1;
      if (issue) begin
        rv <= 1'b1;
        rl <= b == LAST_B;
      end else if (!sv && cons) rv <= 1'b0;
      // A fresh read would overwrite an unaccepted beat, so park it in the skid register
      if (issue && rv && !cons) begin
        sv <= 1'b1;
        s_data <= rd[d];
        sl <= rl;
      end else if (sv && cons) sv <= 1'b0;
    end
  for (genvar i = 0; i < NB; i++) begin : g_bank
    intt_out_bank #(.LOG_CORE_COUNT(LOG_CORE_COUNT)) u_bank (
      .clk(clk),
      .rst_n(rst_n),
      .we(acc && tgt == 1'(i)),
      .waddr(address_in[LW-1:0]),
      .wdata(in),
      .re(issue && d == 1'(i)),
      .raddr(b),
      .rdata(rd[i])
    );
  end
endmodule
